// File: rtl/oled_pixel_streamer.sv
// Serialises a fixed SSD1331 window-setup command block followed by a full frame of
// RGB565 pixels over a 4-wire SPI-style link (sclk = clk/2, MSB first), then idles for a gap.
module oled_pixel_streamer #(
    parameter int FRAME_GAP  = 1000,
    parameter int NUM_PIXELS = 6144
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pixel_data,
    output logic [12:0] pixel_index,
    output logic        frame_begin,
    output logic        sending_pixels,
    output logic        sample_pixel,
    output logic        cs,
    output logic        sclk,
    output logic        sdin,
    output logic        d_cn
);

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_CMD    = 2'd1;
    localparam logic [1:0]  ST_PIXELS = 2'd2;
    localparam logic [1:0]  ST_GAP    = 2'd3;

    localparam int          GAP_W     = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    localparam logic [12:0] LAST_PIX  = 13'(NUM_PIXELS - 1);

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h15;
            3'd1:    b = 8'h00;
            3'd2:    b = 8'h5F;
            3'd3:    b = 8'h75;
            3'd4:    b = 8'h00;
            3'd5:    b = 8'h3F;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic [1:0]       rst_sync_q;
    logic             rst_n_s;
    logic [1:0]       state_q, state_d;
    logic [3:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic [15:0]      sh_q, sh_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [12:0]      pix_q, pix_d;
    logic             last_q, last_d;
    logic             cs_q, cs_d;
    logic             sclk_q, sclk_d;
    logic             d_cn_q, d_cn_d;
    logic             fb_q, fb_d;
    logic             sample_q, sample_d;
    logic             sending_q, sending_d;
    logic [3:0]       last_bit_s;
    logic             word_end_s;

    // Assert asynchronously, release two edges later so no flop sees a partial release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s    = rst_sync_q[1];
    assign last_bit_s = (state_q == ST_PIXELS) ? 4'd15 : 4'd7;
    assign word_end_s = sclk_q && (bit_q == last_bit_s);

    // Next-state logic: bits shift on the sclk falling half, words reload at word end.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh_d      = sh_q;
        gap_d     = gap_q;
        pix_d     = pix_q;
        last_d    = last_q;
        cs_d      = cs_q;
        sclk_d    = 1'b0;
        d_cn_d    = d_cn_q;
        fb_d      = 1'b0;
        sample_d  = 1'b0;
        sending_d = sending_q;
        case (state_q)
            ST_IDLE: begin
                cs_d   = 1'b1;
                d_cn_d = 1'b0;
                if (enable) begin
                    state_d = ST_CMD;
                    fb_d    = 1'b1;
                    cs_d    = 1'b0;
                    sh_d    = {cmd_byte(3'd0), 8'h00};
                    bit_d   = 4'd0;
                    byte_d  = 3'd0;
                    pix_d   = 13'd0;
                    last_d  = 1'b0;
                end else begin
                    sh_d = 16'h0000;
                end
            end
            ST_CMD, ST_PIXELS: begin
                sclk_d = ~sclk_q;
                if (!sclk_q) begin
                    // Pulse one cycle ahead of the load edge so the sample cycle is the load cycle.
                    sample_d = (bit_q == last_bit_s) &&
                               (((state_q == ST_CMD) && (byte_q == 3'd5)) ||
                                ((state_q == ST_PIXELS) && !last_q));
                end else if (!word_end_s) begin
                    bit_d = bit_q + 4'd1;
                    sh_d  = {sh_q[14:0], 1'b0};
                end else if ((state_q == ST_CMD) && (byte_q != 3'd5)) begin
                    byte_d = byte_q + 3'd1;
                    bit_d  = 4'd0;
                    sh_d   = {cmd_byte(byte_q + 3'd1), 8'h00};
                end else if ((state_q == ST_CMD) || !last_q) begin
                    state_d   = ST_PIXELS;
                    sending_d = 1'b1;
                    d_cn_d    = 1'b1;
                    bit_d     = 4'd0;
                    sh_d      = pixel_data;
                    last_d    = (pix_q == LAST_PIX);
                    if (pix_q != LAST_PIX) begin
                        pix_d = pix_q + 13'd1;
                    end else begin
                        pix_d = pix_q;
                    end
                end else begin
                    state_d   = ST_GAP;
                    cs_d      = 1'b1;
                    d_cn_d    = 1'b0;
                    sending_d = 1'b0;
                    pix_d     = 13'd0;
                    sh_d      = 16'h0000;
                    bit_d     = 4'd0;
                    byte_d    = 3'd0;
                    gap_d     = '0;
                    last_d    = 1'b0;
                end
            end
            ST_GAP: begin
                cs_d = 1'b1;
                if (gap_q >= GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cs_d      = 1'b1;
                d_cn_d    = 1'b0;
                sending_d = 1'b0;
                sh_d      = 16'h0000;
                pix_d     = 13'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q   <= ST_IDLE;
            bit_q     <= 4'd0;
            byte_q    <= 3'd0;
            sh_q      <= 16'h0000;
            gap_q     <= '0;
            pix_q     <= 13'd0;
            last_q    <= 1'b0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            d_cn_q    <= 1'b0;
            fb_q      <= 1'b0;
            sample_q  <= 1'b0;
            sending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sh_q      <= sh_d;
            gap_q     <= gap_d;
            pix_q     <= pix_d;
            last_q    <= last_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            d_cn_q    <= d_cn_d;
            fb_q      <= fb_d;
            sample_q  <= sample_d;
            sending_q <= sending_d;
        end
    end

    assign pixel_index    = pix_q;
    assign frame_begin    = fb_q;
    assign sending_pixels = sending_q;
    assign sample_pixel   = sample_q;
    assign cs             = cs_q;
    assign sclk           = sclk_q;
    assign sdin           = sh_q[15];
    assign d_cn           = d_cn_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Random-data bench for oled_pixel_streamer: a serial monitor decodes the link and the
// result is compared against frame contents and timing derived from the protocol rules.
module tb_oled_pixel_streamer;

    localparam int NP  = 64;
    localparam int FG  = 10;
    localparam int CMD_CYC = 96;
    localparam int FRAME_CYC = CMD_CYC + 32 * NP;
    localparam int PERIOD = FRAME_CYC + FG + 1;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [15:0] pixel_data;
    logic [12:0] pixel_index;
    logic        frame_begin, sending_pixels, sample_pixel, cs, sclk, sdin, d_cn;

    logic [15:0] mem [0:8191];
    logic        idx_mode = 1'b0;
    logic [7:0]  exp_cmd [6] = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};

    int n_checks = 0;
    int n_fail = 0;

    oled_pixel_streamer #(.FRAME_GAP(FG), .NUM_PIXELS(NP)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pixel_data(pixel_data),
        .pixel_index(pixel_index), .frame_begin(frame_begin),
        .sending_pixels(sending_pixels), .sample_pixel(sample_pixel),
        .cs(cs), .sclk(sclk), .sdin(sdin), .d_cn(d_cn)
    );

    always #5 clk = ~clk;

    assign pixel_data = idx_mode ? {3'b000, pixel_index} : mem[pixel_index];

    // Monitor state, sampled on the falling clock edge.
    int cyc = 0, fb_cnt = 0, done_cnt = 0, fb_time = 0, fb_period = 0;
    int cmd_nb = 0, w_nb = 0, sp_cnt = 0, sp_first_rel = -1, sp_gap_err = 0, sp_idx_err = 0;
    int last_sp = 0, send_cyc = 0, send_first_rel = -1, gap_rel = -1, sdin_err = 0, cs_err = 0;
    int max_idx = 0, idx_chg = 0;
    logic [7:0]  cmd_sh;
    logic [15:0] w_sh;
    logic [7:0]  cmd_q [$];
    logic [15:0] word_q [$];
    logic [12:0] idx_at_gap, p_idx;
    logic        cs_at_gap, p_sclk = 1'b0, p_sdin = 1'b0, p_send = 1'b0, p_rst = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset && p_rst && (sdin !== p_sdin) && !(p_sclk && !sclk)) sdin_err++;
        if (!reset) begin
            cmd_nb = 0;
            w_nb = 0;
        end else begin
            if (frame_begin) begin
                fb_period = cyc - fb_time;
                fb_time = cyc;
                fb_cnt++;
                cmd_q.delete();
                word_q.delete();
                sp_cnt = 0; sp_gap_err = 0; sp_idx_err = 0; send_cyc = 0;
                send_first_rel = -1; sp_first_rel = -1; cmd_nb = 0; w_nb = 0; max_idx = 0;
                cs_err = 0; sdin_err = 0;
            end
            if (pixel_index !== p_idx) idx_chg = cyc;
            if (sclk && !p_sclk) begin
                if (cs !== 1'b0) cs_err++;
                if (!d_cn) begin
                    cmd_sh = {cmd_sh[6:0], sdin};
                    cmd_nb++;
                    if (cmd_nb == 8) begin cmd_q.push_back(cmd_sh); cmd_nb = 0; end
                end else begin
                    w_sh = {w_sh[14:0], sdin};
                    w_nb++;
                    if (w_nb == 16) begin word_q.push_back(w_sh); w_nb = 0; end
                end
            end
            if (sample_pixel) begin
                if (sp_cnt == 0) sp_first_rel = cyc - fb_time;
                else if (cyc - last_sp != 32) sp_gap_err++;
                if (int'(pixel_index) != sp_cnt) sp_idx_err++;
                if (sp_cnt > 0 && cyc - idx_chg < 30) sp_idx_err++;
                last_sp = cyc;
                sp_cnt++;
            end
            if (sending_pixels) begin
                if (send_cyc == 0) send_first_rel = cyc - fb_time;
                send_cyc++;
            end
            if (int'(pixel_index) > max_idx) max_idx = int'(pixel_index);
            if (p_send && !sending_pixels && p_rst) begin
                gap_rel = cyc - fb_time;
                idx_at_gap = pixel_index;
                cs_at_gap = cs;
                done_cnt++;
            end
        end
        p_sclk = sclk; p_sdin = sdin; p_send = sending_pixels; p_rst = reset; p_idx = pixel_index;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 3 * PERIOD) begin step(1); n++; end
        chk("frame_done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    function automatic logic [15:0] exp_word(input int k);
        return idx_mode ? 16'(k) : mem[k];
    endfunction

    task automatic check_frame(input string t);
        chk({t, "_ncmd"}, 32'(cmd_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < cmd_q.size(); i++)
            chk($sformatf("%s_cmd%0d", t, i), 32'(cmd_q[i]), 32'(exp_cmd[i]));
        chk({t, "_nwords"}, 32'(word_q.size()), 32'(NP));
        for (int k = 0; k < NP && k < word_q.size(); k++)
            chk($sformatf("%s_word%0d", t, k), 32'(word_q[k]), 32'(exp_word(k)));
        chk({t, "_nsamples"}, 32'(sp_cnt), 32'(NP));
        chk({t, "_first_sample"}, 32'(sp_first_rel), 32'(CMD_CYC - 1));
        chk({t, "_sample_spacing"}, 32'(sp_gap_err), 32'd0);
        chk({t, "_sample_index"}, 32'(sp_idx_err), 32'd0);
        chk({t, "_send_cycles"}, 32'(send_cyc), 32'(32 * NP));
        chk({t, "_send_start"}, 32'(send_first_rel), 32'(CMD_CYC));
        chk({t, "_gap_entry"}, 32'(gap_rel), 32'(FRAME_CYC));
        chk({t, "_idx_at_gap"}, 32'(idx_at_gap), 32'd0);
        chk({t, "_cs_at_gap"}, 32'(cs_at_gap), 32'd1);
        chk({t, "_max_index"}, 32'(max_idx), 32'(NP - 1));
        chk({t, "_cs_low"}, 32'(cs_err), 32'd0);
        chk({t, "_sdin_stable"}, 32'(sdin_err), 32'd0);
    endtask

    initial begin
        int n;
        int stop_at;
        reset = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;
        step(3);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_sdin", 32'(sdin), 32'd0);
        chk("rst_dcn", 32'(d_cn), 32'd0);
        chk("rst_fb", 32'(frame_begin), 32'd0);
        chk("rst_send", 32'(sending_pixels), 32'd0);
        chk("rst_sample", 32'(sample_pixel), 32'd0);
        chk("rst_index", 32'(pixel_index), 32'd0);

        reset = 1'b1;
        step(5);
        chk("idle_no_frame", 32'(fb_cnt), 32'd0);
        chk("idle_cs", 32'(cs), 32'd1);

        // Frame 1: random pixels, enable held high.
        enable = 1'b1;
        wait_done(1);
        check_frame("f1");

        // Frame 2 starts by itself; pixel data tracks the index.
        idx_mode = 1'b1;
        wait_done(2);
        check_frame("f2");
        chk("fb_count_2", 32'(fb_cnt), 32'd2);
        chk("frame_period", 32'(fb_period), 32'(PERIOD));

        // Frame 3: new random data, enable dropped partway through.
        idx_mode = 1'b0;
        for (int i = 0; i < NP; i++) mem[i] = 16'($urandom);
        n = 0;
        while (!(sending_pixels && pixel_index == 13'd20) && n < 2 * PERIOD) begin step(1); n++; end
        chk("reach_pixel20", 32'(n < 2 * PERIOD), 32'd1);
        enable = 1'b0;
        wait_done(3);
        check_frame("f3");
        step(3 * PERIOD);
        chk("no_restart_fb", 32'(fb_cnt), 32'd3);
        chk("no_restart_cs", 32'(cs), 32'd1);

        // Reset mid-pixel while sclk is high, then restart.
        enable = 1'b1;
        stop_at = $urandom_range(5, NP - 5);
        n = 0;
        while (!(sending_pixels && int'(pixel_index) >= stop_at && sclk) && n < 2 * PERIOD) begin
            step(1); n++;
        end
        chk("reach_abort_point", 32'(n < 2 * PERIOD), 32'd1);
        chk("abort_sclk_high", 32'(sclk), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_send", 32'(sending_pixels), 32'd0);
        chk("abort_index", 32'(pixel_index), 32'd0);
        step(3);
        reset = 1'b1;
        wait_done(4);
        check_frame("f5");
        chk("fb_count_restart", 32'(fb_cnt), 32'd5);
        enable = 1'b0;
        step(FG + 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
